// File: rtl/result_drain_packer.sv
// Drains one tile of FP16 results from a 1-cycle-latency FIFO read port and
// packs LANES elements per word onto a valid/ready stream.
`timescale 1ns/1ps
module result_drain_packer #(
   parameter int unsigned LANES = 16
) (
   input  logic                  i_clk,
   input  logic                  i_reset_n,
   input  logic                  i_tile_start,
   input  logic [14:0]           i_tile_els,
   output logic                  o_rd_en,
   input  logic [15:0]           i_rd_data,
   input  logic                  i_empty,
   output logic [16*LANES-1:0]   o_data,
   output logic [LANES-1:0]      o_keep,
   output logic                  o_last,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic                  o_busy,
   output logic                  o_done
);

   localparam int unsigned EL_W   = 15;
   localparam int unsigned LANE_W = $clog2(LANES);
   localparam int unsigned ACC_W  = LANE_W + 1;
   localparam int unsigned DATA_W = 16 * LANES;

   typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_DONE} state_t;

   state_t            state;
   logic [EL_W-1:0]   tile_els;
   logic [EL_W-1:0]   issued;
   logic [ACC_W-1:0]  acc_cnt;
   logic              pending;
   logic [15:0]       acc [LANES];

   logic              all_issued;
   logic              room;
   logic              word_ready;
   logic              xfer;
   logic              hs;
   logic [DATA_W-1:0] pack;
   logic [LANES-1:0]  keep;

   assign all_issued = (issued == tile_els);
   assign room       = (acc_cnt + ACC_W'(pending)) < ACC_W'(LANES);
   assign word_ready = (acc_cnt == ACC_W'(LANES)) ||
                       (all_issued && !pending && (acc_cnt != '0));
   assign hs         = o_valid && i_ready;
   assign xfer       = (state == S_DRAIN) && word_ready && (!o_valid || i_ready);

   // Reads are never speculative and are suppressed during reset so an aborted tile cannot pull data.
   assign o_rd_en = i_reset_n && (state == S_DRAIN) && !i_empty &&
                    (issued < tile_els) && room;

   // Outgoing word: filled lanes from the accumulator, unfilled lanes zeroed.
   always_comb begin
      pack = '0;
      keep = '0;
      for (int k = 0; k < LANES; k++) begin
         if (ACC_W'(k) < acc_cnt) begin
            pack[16*k +: 16] = acc[k];
            keep[k]          = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state    <= S_IDLE;
         tile_els <= '0;
         issued   <= '0;
         acc_cnt  <= '0;
         pending  <= 1'b0;
         o_data   <= '0;
         o_keep   <= '0;
         o_last   <= 1'b0;
         o_valid  <= 1'b0;
         o_busy   <= 1'b0;
         o_done   <= 1'b0;
         for (int k = 0; k < LANES; k++) acc[k] <= '0;
      end else begin
         o_done  <= 1'b0;
         pending <= o_rd_en;
         if (o_rd_en) issued <= EL_W'(issued + 1'b1);

         // Read data lands one cycle after the strobe, in arrival order.
         if (pending) begin
            acc[acc_cnt[LANE_W-1:0]] <= i_rd_data;
            acc_cnt                  <= ACC_W'(acc_cnt + 1'b1);
         end

         // A transfer never coincides with a landing: it needs a full accumulator or no read in flight.
         if (xfer) begin
            o_data  <= pack;
            o_keep  <= keep;
            o_last  <= all_issued && !pending;
            o_valid <= 1'b1;
            acc_cnt <= '0;
         end else if (hs) begin
            o_valid <= 1'b0;
         end

         case (state)
            S_IDLE: begin
               if (i_tile_start && !o_done) begin
                  tile_els <= i_tile_els;
                  issued   <= '0;
                  acc_cnt  <= '0;
                  o_busy   <= 1'b1;
                  state    <= (i_tile_els == '0) ? S_DONE : S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (hs && o_last) state <= S_DONE;
            end
            S_DONE: begin
               o_done <= 1'b1;
               o_busy <= 1'b0;
               state  <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
